// File: rtl/generic_sram_pkg.sv
// Shared definitions for the generic SRAM client family: default widths,
// request kind encoding and a pointer-width helper.
package generic_sram_pkg;

  localparam int DEFAULT_ADDR_BITS = 32;
  localparam int DEFAULT_DATA_BITS = 32;
  localparam int DEFAULT_RSP_DEPTH = 2;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

  // Bits needed to index n entries, never less than one so depth-1 storage still gets a pointer.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/generic_sram_line_en_if.sv
// Line-enable single-port SRAM interface: separate read/write enables,
// one-cycle registered read data.
interface generic_sram_line_en_if
  import generic_sram_pkg::*;
#(
  parameter int NUM_ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int NUM_DATA_BITS = DEFAULT_DATA_BITS
);

  logic [NUM_ADDR_BITS-1:0] addr;
  logic [NUM_DATA_BITS-1:0] write_data;
  logic                     write_en;
  logic                     read_en;
  logic [NUM_DATA_BITS-1:0] read_data;

  modport sram_client (
    output addr,
    output write_data,
    output write_en,
    output read_en,
    input  read_data
  );

  modport sram (
    input  addr,
    input  write_data,
    input  write_en,
    input  read_en,
    output read_data
  );

endinterface

// File: rtl/generic_sram_rsp_fifo.sv
// Response FIFO shared by SRAM clients: registered storage, combinational head,
// explicit pointer wrap so any depth >= 2 is legal.
module generic_sram_rsp_fifo
  import generic_sram_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_DATA_BITS,
  parameter  int DEPTH = DEFAULT_RSP_DEPTH,
  localparam int PTR_W = clog2_min1(DEPTH),
  localparam int CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Popping an empty FIFO is ignored rather than corrupting the count.
  assign pop_ok   = pop && (count != '0);
  assign out_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop_ok) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(push && (count == CNT_W'(DEPTH))))
        else $error("generic_sram_rsp_fifo: push into full FIFO");
    end
  end

endmodule

// File: rtl/generic_sram_line_en_client.sv
// Valid/ready request stream to line-enable SRAM client adapter; read data
// returns in order through a credit-guarded response FIFO.
module generic_sram_line_en_client
  import generic_sram_pkg::*;
#(
  parameter int NUM_ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int NUM_DATA_BITS = DEFAULT_DATA_BITS,
  parameter int RSP_DEPTH     = DEFAULT_RSP_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [NUM_ADDR_BITS-1:0] req_addr,
  input  logic [NUM_DATA_BITS-1:0] req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NUM_DATA_BITS-1:0] rsp_data,
  generic_sram_line_en_if.sram_client sram
);

  localparam int CNT_W = clog2_min1(RSP_DEPTH + 1);

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credits_used;
  logic             inflight;
  logic             acc;
  logic             pop;
  req_kind_e        kind;

  assign kind = req_kind_e'(req_write);

  // Every request consumes a credit slot check, so writes never overtake queued reads.
  assign credits_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign req_ready    = credits_used < (CNT_W + 1)'(RSP_DEPTH);

  // Enables are held off while reset is asserted even though req_ready reads 1.
  assign acc = req_valid && req_ready && rstn;

  assign sram.addr       = req_addr;
  assign sram.write_data = req_wdata;
  assign sram.write_en   = acc && (kind == REQ_WRITE);
  assign sram.read_en    = acc && (kind == REQ_READ);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= 1'b0;
    end else begin
      inflight <= acc && (kind == REQ_READ);
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;

  generic_sram_rsp_fifo #(
    .WIDTH (NUM_DATA_BITS),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight),
    .push_data (sram.read_data),
    .pop       (pop),
    .count     (fifo_count),
    .out_data  (rsp_data)
  );

endmodule
